// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the fetch entry layout used by the IF/ID buffer.
package pipe_pkg;

  localparam int unsigned IF_ID_DEPTH      = 2;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// Circular store of fetch entries with head/tail/count; one-cycle write-to-read latency.
module if_id_fifo
  import pipe_pkg::*;
#(
  parameter  int DEPTH = IF_ID_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  output fetch_entry_t o_head_dat,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Pointers are AW bits wide, so increments wrap modulo DEPTH (power of two).
  always_ff @(posedge Clk) begin
    if (Rst || i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (i_push) r_mem[r_tail] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_head];
  assign o_count    = r_count;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: flush squashes all entries, empty head reads as NOP, PC+4 for decode.
module if_id_buffer
  import pipe_pkg::*;
#(
  parameter int          DEPTH    = IF_ID_DEPTH,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            fetchInst,
  input  logic [31:0]            fetchPC,
  input  logic                   fetchHit,
  input  logic                   flush,
  input  logic                   decodeReady,
  output logic [31:0]            idInst,
  output logic [31:0]            idPC,
  output logic [31:0]            idPCPlusFour,
  output logic                   idValid,
  output logic                   fetchStall,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_push_dat;
  fetch_entry_t w_head;

  assign w_empty    = (count == '0);
  assign fetchStall = (count == CW'(DEPTH));
  assign w_push     = fetchHit && !fetchStall && !flush;
  // A flushed head is never reported valid, so it cannot be consumed.
  assign idValid    = !w_empty && !flush;
  assign w_pop      = idValid && decodeReady;

  assign w_push_dat.inst = fetchInst;
  assign w_push_dat.pc   = fetchPC;

  if_id_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_clear   (flush),
    .i_push    (w_push),
    .i_push_dat(w_push_dat),
    .i_pop     (w_pop),
    .o_head_dat(w_head),
    .o_count   (count)
  );

  assign idInst       = w_empty ? NOP_INST : w_head.inst;
  assign idPC         = w_empty ? 32'h0 : w_head.pc;
  assign idPCPlusFour = idPC + PC_INCR;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed checks of the IF/ID buffer at DEPTH=2 with hand-computed expectations.
module tb_if_id_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] fetchInst;
  logic [31:0] fetchPC;
  logic        fetchHit;
  logic        flush;
  logic        decodeReady;
  logic [31:0] idInst;
  logic [31:0] idPC;
  logic [31:0] idPCPlusFour;
  logic        idValid;
  logic        fetchStall;
  logic [1:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  if_id_buffer dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .fetchInst   (fetchInst),
    .fetchPC     (fetchPC),
    .fetchHit    (fetchHit),
    .flush       (flush),
    .decodeReady (decodeReady),
    .idInst      (idInst),
    .idPC        (idPC),
    .idPCPlusFour(idPCPlusFour),
    .idValid     (idValid),
    .fetchStall  (fetchStall),
    .count       (count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic hit, input logic [31:0] inst, input logic [31:0] pc);
    fetchHit  = hit;
    fetchInst = inst;
    fetchPC   = pc;
  endtask

  initial begin
    Rst = 1'b1; flush = 1'b0; decodeReady = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    Rst = 1'b0;
    #1;
    chk("rst_valid", idValid, 0);
    chk("rst_stall", fetchStall, 0);
    chk("rst_inst", idInst, 32'h0);
    chk("rst_pc", idPC, 32'h0);
    chk("rst_pc4", idPCPlusFour, 32'h4);
    chk("rst_count", count, 0);

    // First push appears one cycle later
    fetch(1'b1, 32'h2010_0005, 32'h0000_0000);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    #1;
    chk("p1_valid", idValid, 1);
    chk("p1_inst", idInst, 32'h2010_0005);
    chk("p1_pc4", idPCPlusFour, 32'h4);
    chk("p1_count", count, 1);

    // Fill to DEPTH, then a third hit must be dropped
    fetch(1'b1, 32'h1111_1111, 32'h0000_0004);
    tick();
    chk("full_count", count, 2);
    chk("full_stall", fetchStall, 1);
    fetch(1'b1, 32'h3333_3333, 32'h0000_0008);
    tick();
    chk("drop_count", count, 2);
    chk("drop_inst", idInst, 32'h2010_0005);
    fetch(1'b0, 32'h0, 32'h0);
    decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    #1;
    chk("pop_count", count, 1);
    chk("pop_stall", fetchStall, 0);
    chk("pop_inst", idInst, 32'h1111_1111);
    chk("pop_pc", idPC, 32'h4);

    // Simultaneous push and pop in PARTIAL; tail wraps to slot 0
    fetch(1'b1, 32'h3333_3333, 32'h0000_0008);
    decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    #1;
    chk("pp_count", count, 1);
    chk("pp_pc", idPC, 32'h8);
    chk("pp_inst", idInst, 32'h3333_3333);

    // Refill, then flush with a concurrent hit and ready
    fetch(1'b1, 32'h4444_4444, 32'h0000_000C);
    tick();
    chk("pre_flush_count", count, 2);
    fetch(1'b1, 32'h5555_5555, 32'h0000_0010);
    flush = 1'b1;
    decodeReady = 1'b1;
    #1;
    chk("flush_cyc_valid", idValid, 0);
    tick();
    flush = 1'b0;
    decodeReady = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid", idValid, 0);
    chk("flush_inst", idInst, 32'h0);

    // After flush the pointers are realigned
    fetch(1'b1, 32'h6666_6666, 32'h0000_0100);
    tick();
    fetch(1'b0, 32'h0, 32'h0);
    #1;
    chk("post_flush_inst", idInst, 32'h6666_6666);
    chk("post_flush_count", count, 1);
    decodeReady = 1'b1;
    tick();
    decodeReady = 1'b0;
    #1;
    chk("drain_count", count, 0);
    chk("drain_valid", idValid, 0);
    chk("drain_inst", idInst, 32'h0);

    // PC+4 wraps at 2^32
    fetch(1'b1, 32'h7777_7777, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", idPC, 32'hFFFF_FFFC);
    chk("wrap_pc4", idPCPlusFour, 32'h0);

    // Reset beats push and pop while full
    fetch(1'b1, 32'h8888_8888, 32'h0000_0000);
    tick();
    chk("rst_full_count", count, 2);
    Rst = 1'b1;
    decodeReady = 1'b1;
    tick();
    Rst = 1'b0;
    decodeReady = 1'b0;
    fetch(1'b0, 32'h0, 32'h0);
    #1;
    chk("rst2_count", count, 0);
    chk("rst2_stall", fetchStall, 0);
    chk("rst2_valid", idValid, 0);
    chk("rst2_pc4", idPCPlusFour, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
